// File: rtl/bus_pkg.sv
// Shared definitions for the serial system-bus master ports: FSM states,
// transfer-mode encodings and header sizing helpers.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WLOAD,
        WSHIFT,
        RDATA,
        DONE
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Header is the start address followed by the length field, sent as one word.
    function automatic int hdr_width(input int addr_width, input int len_width);
        return addr_width + len_width;
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register. Shifting moves contents toward bit 0 (bit 0 is
// the serial output) and inserts sin at the MSB, so LSB-first input assembles in place.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/burst_master_port.sv
// Burst master for the one-bit system bus: header, then LSB-first data beats.
// Define BURST_MASTER_TIMEOUT_EN to enable the read-response timeout (derr).
module burst_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [LEN_WIDTH-1:0]  dlen,
    input  logic [DATA_WIDTH-1:0] dwdata,
    input  logic                  dwvalid,
    output logic                  dwready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  drvalid,
    output logic                  dlast,
    output logic                  derr,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid
);

    localparam int HW   = hdr_width(ADDR_WIDTH, LEN_WIDTH);
    localparam int SR_W = max_width(HW, DATA_WIDTH);
    localparam int CW   = $clog2(SR_W + 1);
    // One extra bit so the counter can pass an all-ones dlen.
    localparam int BW   = LEN_WIDTH + 1;

    localparam logic [CW-1:0] HDR_LAST  = CW'(HW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    state_t               state;
    logic [LEN_WIDTH-1:0] dlen_q;
    logic [BW-1:0]        beat_cnt;
    logic [BW-1:0]        beat_next;
    logic [CW-1:0]        bit_cnt;

    logic                  tx_load;
    logic [SR_W-1:0]       tx_load_data;
    logic                  tx_shift;
    logic [SR_W-1:0]       tx_q;
    logic                  rx_shift;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  unused_sr_bits;

    assign beat_next = beat_cnt + BW'(1);

    // Drained positions refill with zeros, so tx_q[0] idles low between shifts.
    assign mwdata         = tx_q[0];
    assign unused_sr_bits = ^{tx_q[SR_W-1:1], rx_q[0]};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        tx_load      = 1'b0;
        tx_load_data = '0;
        tx_shift     = 1'b0;
        rx_shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dvalid && dready) begin
                    tx_load      = 1'b1;
                    tx_load_data = SR_W'({dlen, daddr});
                end
            end
            HDR, WSHIFT: tx_shift = 1'b1;
            WLOAD: begin
                if (dwvalid && dwready) begin
                    tx_load      = 1'b1;
                    tx_load_data = SR_W'(dwdata);
                end
            end
            RDATA:   rx_shift = svalid && !dlast && !derr;
            default: ;
        endcase
    end

    serial_shift_reg #(.WIDTH(SR_W)) u_tx_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (tx_load_data),
        .shift     (tx_shift),
        .sin       (1'b0),
        .q         (tx_q)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .sin       (mrdata),
        .q         (rx_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dready   <= 1'b1;
            dwready  <= 1'b0;
            drdata   <= '0;
            drvalid  <= 1'b0;
            dlast    <= 1'b0;
            mmode    <= MODE_READ;
            mvalid   <= 1'b0;
            dlen_q   <= '0;
            beat_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            drvalid <= 1'b0;
            dlast   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dvalid && dready) begin
                        dlen_q   <= dlen;
                        mmode    <= dmode;
                        beat_cnt <= '0;
                        bit_cnt  <= '0;
                        dready   <= 1'b0;
                        mvalid   <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == HDR_LAST) begin
                        bit_cnt <= '0;
                        mvalid  <= 1'b0;
                        if (mmode == MODE_WRITE) begin
                            dwready <= 1'b1;
                            state   <= WLOAD;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                WLOAD: begin
                    if (dwvalid && dwready) begin
                        dwready <= 1'b0;
                        mvalid  <= 1'b1;
                        state   <= WSHIFT;
                    end
                end
                WSHIFT: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt  <= '0;
                        mvalid   <= 1'b0;
                        beat_cnt <= beat_next;
                        if (beat_next > {1'b0, dlen_q}) begin
                            mmode <= MODE_READ;
                            state <= DONE;
                        end else begin
                            dwready <= 1'b1;
                            state   <= WLOAD;
                        end
                    end
                end
                RDATA: begin
                    // The final-beat and timeout pulses are themselves the exit cue,
                    // so DONE follows the pulse cycle and later bus bits are ignored.
                    if (dlast || derr) begin
                        mmode <= MODE_READ;
                        state <= DONE;
                    end else if (svalid) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt  <= '0;
                            drdata   <= {mrdata, rx_q[DATA_WIDTH-1:1]};
                            drvalid  <= 1'b1;
                            beat_cnt <= beat_next;
                            dlast    <= (beat_next > {1'b0, dlen_q});
                        end
                    end
                end
                DONE: begin
                    dready <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    // Counts silent cycles in RDATA; any slave bit restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            derr    <= 1'b0;
        end else begin
            derr <= 1'b0;
            if (state != RDATA || svalid || dlast || derr) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt == TMO_LAST) begin
                    derr <= 1'b1;
                end
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign derr = 1'b0;
`endif

endmodule

// File: tb/tb_burst_master_port.sv
// Directed self-checking bench for burst_master_port (default parameters,
// TIMEOUT=16 so the timeout build can be exercised with the same bench).
module tb_burst_master_port;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int HW = AW + LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dvalid = 1'b0;
    logic          dready;
    logic          dmode = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [LW-1:0] dlen = '0;
    logic [DW-1:0] dwdata = '0;
    logic          dwvalid = 1'b0;
    logic          dwready;
    logic [DW-1:0] drdata;
    logic          drvalid;
    logic          dlast;
    logic          derr;
    logic          mwdata;
    logic          mmode;
    logic          mvalid;
    logic          mrdata = 1'b0;
    logic          svalid = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Captured transaction observations.
    logic [HW-1:0] hdr_val;
    logic [127:0]  wr_got;
    int            nbits, wbits, ready_cyc, first_dwready, max_gap, mode_bad;
    logic [DW-1:0] wdata [0:15];
    logic [DW-1:0] rbeats [0:19];
    logic [DW-1:0] rd_got [0:31];
    logic          rd_last [0:31];
    int            npulse, nlast, last_pulse_cyc, nderr, derr_cyc;

    burst_master_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dvalid  (dvalid),
        .dready  (dready),
        .dmode   (dmode),
        .daddr   (daddr),
        .dlen    (dlen),
        .dwdata  (dwdata),
        .dwvalid (dwvalid),
        .dwready (dwready),
        .drdata  (drdata),
        .drvalid (drvalid),
        .dlast   (dlast),
        .derr    (derr),
        .mwdata  (mwdata),
        .mmode   (mmode),
        .mvalid  (mvalid),
        .mrdata  (mrdata),
        .svalid  (svalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write burst and play the device side; observe until dready returns.
    task automatic run_write(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int stall_beat, input int stall_cycles, input int max_cyc);
        int cyc, beat, stall, gap;
        hdr_val = '0; wr_got = '0; nbits = 0; wbits = 0; ready_cyc = -1;
        first_dwready = -1; max_gap = 0; mode_bad = 0;
        dvalid = 1'b1; dmode = 1'b1; daddr = addr; dlen = len; dwvalid = 1'b0;
        tick();
        dvalid = 1'b0; daddr = '1; dlen = '0; dmode = 1'b0;
        cyc = 1; beat = 0; stall = 0; gap = 0;
        while (cyc < max_cyc) begin
            if (mvalid) begin
                if (nbits < HW) hdr_val[nbits] = mwdata;
                else begin
                    wr_got[wbits] = mwdata;
                    wbits++;
                end
                nbits++;
                if (mmode !== 1'b1) mode_bad++;
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end else if (nbits >= HW) begin
                gap++;
            end
            if (dwready && first_dwready < 0) first_dwready = cyc;
            if (dready) begin
                ready_cyc = cyc;
                break;
            end
            if (dwready && beat <= int'(len)) begin
                if (beat == stall_beat && stall < stall_cycles) begin
                    dwvalid = 1'b0;
                    stall++;
                end else begin
                    dwvalid = 1'b1;
                    dwdata  = wdata[beat];
                    beat++;
                end
            end else begin
                dwvalid = 1'b0;
            end
            tick();
            cyc++;
        end
        dwvalid = 1'b0;
    endtask

    // Issue a read burst; the slave streams rbeats LSB-first with a gap every third cycle.
    task automatic run_read(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input bit silent, input int max_cyc);
        int cyc, sidx;
        logic [DW-1:0] b;
        hdr_val = '0; nbits = 0; mode_bad = 0; ready_cyc = -1;
        npulse = 0; nlast = 0; last_pulse_cyc = -1; nderr = 0; derr_cyc = -1;
        dvalid = 1'b1; dmode = 1'b0; daddr = addr; dlen = len;
        tick();
        dvalid = 1'b0; daddr = '1; dlen = '0; dmode = 1'b1;
        cyc = 1; sidx = 0;
        while (cyc < max_cyc) begin
            if (mvalid) begin
                if (nbits < HW) hdr_val[nbits] = mwdata;
                nbits++;
                if (mmode !== 1'b0) mode_bad++;
            end
            if (drvalid) begin
                if (npulse < 32) begin
                    rd_got[npulse]  = drdata;
                    rd_last[npulse] = dlast;
                end
                npulse++;
                last_pulse_cyc = cyc;
            end
            if (dlast) nlast++;
            if (derr) begin
                nderr++;
                derr_cyc = cyc;
            end
            if (dready) begin
                ready_cyc = cyc;
                break;
            end
            if (!silent && nbits >= HW && !mvalid && (cyc % 3 != 0)) begin
                b = (sidx / DW < 20) ? rbeats[sidx / DW] : 8'hFF;
                svalid = 1'b1;
                mrdata = b[sidx % DW];
                sidx++;
            end else begin
                svalid = 1'b0;
                mrdata = 1'b0;
            end
            tick();
            cyc++;
        end
        svalid = 1'b0;
        mrdata = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if (dready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_dready: got %b expected 1", dready);
        end
        tests_run++;
        if ({dwready, drvalid, dlast, derr, mwdata, mmode, mvalid} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {dwready, drvalid, dlast, derr, mwdata, mmode, mvalid});
        end
        tests_run++;
        if (drdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_drdata: got %h expected 00", drdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_single();
        wdata[0] = 8'h5A;
        run_write(16'h0ABC, 4'd0, -1, 0, 200);
        tests_run++;
        if (hdr_val !== 20'h00ABC) begin
            tests_failed++;
            $display("FAIL wr1_header: got %h expected 00abc", hdr_val);
        end
        tests_run++;
        if (wbits !== 8 || wr_got[7:0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL wr1_data: got %0d bits %h expected 8 bits 5a", wbits, wr_got[7:0]);
        end
        tests_run++;
        if (mode_bad !== 0) begin
            tests_failed++;
            $display("FAIL wr1_mmode: got %0d bad cycles expected 0", mode_bad);
        end
        tests_run++;
        if (first_dwready !== 21) begin
            tests_failed++;
            $display("FAIL wr1_dwready_cycle: got %0d expected 21", first_dwready);
        end
        tests_run++;
        if (ready_cyc !== 31) begin
            tests_failed++;
            $display("FAIL wr1_duration: got %0d expected 31", ready_cyc);
        end
    endtask

    task automatic test_write_burst();
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        run_write(16'h1357, 4'd3, 1, 5, 300);
        tests_run++;
        if (hdr_val !== 20'h31357) begin
            tests_failed++;
            $display("FAIL wr4_header: got %h expected 31357", hdr_val);
        end
        tests_run++;
        if (wbits !== 32 || wr_got[31:0] !== 32'h44332211) begin
            tests_failed++;
            $display("FAIL wr4_data: got %0d bits %h expected 32 bits 44332211", wbits, wr_got[31:0]);
        end
        tests_run++;
        if (max_gap !== 6) begin
            tests_failed++;
            $display("FAIL wr4_stall_gap: got %0d expected 6", max_gap);
        end
        tests_run++;
        if (ready_cyc !== 63) begin
            tests_failed++;
            $display("FAIL wr4_duration: got %0d expected 63", ready_cyc);
        end
    endtask

    task automatic test_read_gaps();
        for (int i = 0; i < 20; i++) rbeats[i] = 8'hC3;
        rbeats[0] = 8'hA5;
        rbeats[1] = 8'h3C;
        run_read(16'h2468, 4'd1, 1'b0, 300);
        tests_run++;
        if (hdr_val !== 20'h12468 || mode_bad !== 0) begin
            tests_failed++;
            $display("FAIL rd2_header: got %h (mode errs %0d) expected 12468", hdr_val, mode_bad);
        end
        tests_run++;
        if (npulse !== 2) begin
            tests_failed++;
            $display("FAIL rd2_pulses: got %0d expected 2", npulse);
        end
        tests_run++;
        if (rd_got[0] !== 8'hA5 || rd_got[1] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL rd2_data: got %h %h expected a5 3c", rd_got[0], rd_got[1]);
        end
        tests_run++;
        if (rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1 || nlast !== 1) begin
            tests_failed++;
            $display("FAIL rd2_dlast: got %b%b count %0d expected 01 count 1", rd_last[0], rd_last[1], nlast);
        end
        tests_run++;
        if (ready_cyc - last_pulse_cyc !== 2) begin
            tests_failed++;
            $display("FAIL rd2_ready_delay: got %0d expected 2", ready_cyc - last_pulse_cyc);
        end
    endtask

    task automatic test_read_max_burst();
        for (int i = 0; i < 20; i++) rbeats[i] = 8'(i * 37 + 5);
        run_read(16'hFFFF, 4'hF, 1'b0, 1000);
        tests_run++;
        if (npulse !== 16) begin
            tests_failed++;
            $display("FAIL rd16_pulses: got %0d expected 16", npulse);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (rd_got[i] !== rbeats[i]) begin
                tests_failed++;
                $display("FAIL rd16_beat%0d: got %h expected %h", i, rd_got[i], rbeats[i]);
            end
        end
        tests_run++;
        if (rd_last[15] !== 1'b1 || nlast !== 1) begin
            tests_failed++;
            $display("FAIL rd16_dlast: got %b count %0d expected 1 count 1", rd_last[15], nlast);
        end
        tests_run++;
        if (ready_cyc < 0) begin
            tests_failed++;
            $display("FAIL rd16_complete: got no dready expected dready");
        end
    endtask

`ifdef BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        run_read(16'h0101, 4'd0, 1'b1, 200);
        tests_run++;
        if (nderr !== 1 || derr_cyc !== 37) begin
            tests_failed++;
            $display("FAIL tmo_derr: got %0d pulses at %0d expected 1 at 37", nderr, derr_cyc);
        end
        tests_run++;
        if (npulse !== 0 || nlast !== 0) begin
            tests_failed++;
            $display("FAIL tmo_no_data: got %0d drvalid %0d dlast expected 0 0", npulse, nlast);
        end
        tests_run++;
        if (ready_cyc !== 39) begin
            tests_failed++;
            $display("FAIL tmo_ready: got %0d expected 39", ready_cyc);
        end
    endtask
`else
    task automatic test_timeout();
        run_read(16'h0101, 4'd0, 1'b1, 80);
        tests_run++;
        if (ready_cyc !== -1 || nderr !== 0 || npulse !== 0) begin
            tests_failed++;
            $display("FAIL notmo_wait: got ready %0d derr %0d drvalid %0d expected -1 0 0",
                     ready_cyc, nderr, npulse);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (dready !== 1'b1) begin
            tests_failed++;
            $display("FAIL notmo_recover: got %b expected 1", dready);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        dvalid = 1'b1; dmode = 1'b1; daddr = 16'h1234; dlen = 4'd2;
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < HW; i++) tick();
        dwvalid = 1'b1;
        dwdata  = 8'hFF;
        tick();
        dwvalid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (mvalid !== 1'b1 || mwdata !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got mvalid %b mwdata %b expected 1 1", mvalid, mwdata);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mvalid, mwdata, dwready, mmode} !== 4'b0000 || dready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_abort: got mvalid/mwdata/dwready/mmode %b dready %b expected 0000 1",
                     {mvalid, mwdata, dwready, mmode}, dready);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) rbeats[i] = 8'h00;
        rbeats[0] = 8'h96;
        run_read(16'h0042, 4'd0, 1'b0, 200);
        tests_run++;
        if (npulse !== 1 || rd_got[0] !== 8'h96 || rd_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_read: got %0d pulses data %h last %b expected 1 96 1",
                     npulse, rd_got[0], rd_last[0]);
        end
        tests_run++;
        if (ready_cyc < 0) begin
            tests_failed++;
            $display("FAIL rstmid_read_done: got no dready expected dready");
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_write_burst();
        test_read_gaps();
        test_read_max_burst();
        test_timeout();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
